// File: rtl/masked_sbox_pkg.sv
// Shared types and constants for the masked AES S-box sequencer.
// Bundle layout on rnd_data is {r3, r2, r1} with r1 in the LSBs.
package masked_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int SBOX_LAT = 3;

    localparam int DEF_R1_W = 18;
    localparam int DEF_R2_W = 14;
    localparam int DEF_R3_W = 18;

    // Bit offsets of the r2 and r3 slices inside a packed bundle.
    function automatic int r2_lsb(input int r1_w);
        return r1_w;
    endfunction

    function automatic int r3_lsb(input int r1_w, input int r2_w);
        return r1_w + r2_w;
    endfunction

endpackage

// File: rtl/masked_rnd_delay.sv
// Valid-gated randomness delay line: a slice captured with its token is
// shifted alongside it, and bubbles carry all-zero randomness.
module masked_rnd_delay #(
    parameter int W     = 14,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0][W-1:0] dat_q;
    logic [DEPTH-1:0][W-1:0] dat_d;

    // Gating at entry is enough: a zero slice then travels with the bubble.
    always_comb begin
        // NOTE: assign a default before any branch so the block never infers a latch.
        dat_d    = '0;
        dat_d[0] = in_vld ? in_data : '0;
        for (int i = 1; i < DEPTH; i++) begin
            dat_d[i] = dat_q[i-1];
        end
    end

    // NOTE: state flops use non-blocking (<=) so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign out_data = dat_q[DEPTH-1];

endmodule

// File: rtl/masked_sbox_sequencer.sv
// Sequences one masked SubBytes pass: issues byte indices, pulls one PRNG
// bundle per byte and re-times its slices to the S-box pipeline stages.
module masked_sbox_sequencer
    import masked_sbox_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int IDX_W  = 4,
    parameter int LAT    = SBOX_LAT,
    parameter int R1_W   = DEF_R1_W,
    parameter int R2_W   = DEF_R2_W,
    parameter int R3_W   = DEF_R3_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            rd_idx,
    output logic                        issue,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    input  logic [R1_W+R2_W+R3_W-1:0]   rnd_data,
    output logic [R1_W-1:0]             ran_s1,
    output logic [R2_W-1:0]             ran_s2,
    output logic [R3_W-1:0]             ran_s3,
    output logic                        wr_en,
    output logic [IDX_W-1:0]            wr_idx
);

    localparam int R2_LSB = r2_lsb(R1_W);
    localparam int R3_LSB = r3_lsb(R1_W, R2_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          last_idx_q, last_idx_d;
    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;

    // State register and token tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
            vld_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (rnd_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; issue and rnd_ready are the same handshake in RUN.
    always_comb begin
        busy      = (state_q != IDLE);
        issue     = (state_q == RUN) && rnd_valid;
        rnd_ready = issue;
        rd_idx    = issue ? cnt_q : last_idx_q;
        ran_s1    = issue ? rnd_data[R1_W-1:0] : '0;
        done      = (state_q == DRAIN) && vld_q[LAT-1] && (idx_q[LAT-1] == LAST_IDX);
    end

    // A bubble enters stage 1 whenever nothing is issued.
    always_comb begin
        last_idx_d = issue ? cnt_q : last_idx_q;
        vld_d      = {vld_q[LAT-2:0], issue};
        idx_d      = {idx_q[LAT-2:0], rd_idx};
    end

    assign wr_en  = vld_q[LAT-1];
    assign wr_idx = idx_q[LAT-1];

    masked_rnd_delay #(
        .W     (R2_W),
        .DEPTH (1)
    ) u_r2_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (issue),
        .in_data  (rnd_data[R3_LSB-1:R2_LSB]),
        .out_data (ran_s2)
    );

    masked_rnd_delay #(
        .W     (R3_W),
        .DEPTH (LAT - 1)
    ) u_r3_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (issue),
        .in_data  (rnd_data[R3_LSB+R3_W-1:R3_LSB]),
        .out_data (ran_s3)
    );

endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Self-checking bench: directed pass table plus randomized traffic, all
// compared cycle by cycle against a transaction-history reference model.
module tb_masked_sbox_sequencer;

    localparam int NBYTES = 16;
    localparam int IDX_W  = 4;
    localparam int LAT    = 3;
    localparam int R1_W   = 18;
    localparam int R2_W   = 14;
    localparam int R3_W   = 18;
    localparam int RND_W  = R1_W + R2_W + R3_W;
    localparam int MAXC   = 64;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] rd_idx;
    logic             issue;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd_data;
    logic [R1_W-1:0]  ran_s1;
    logic [R2_W-1:0]  ran_s2;
    logic [R3_W-1:0]  ran_s3;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;

    masked_sbox_sequencer #(
        .NBYTES (NBYTES),
        .IDX_W  (IDX_W),
        .LAT    (LAT),
        .R1_W   (R1_W),
        .R2_W   (R2_W),
        .R3_W   (R3_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_idx    (rd_idx),
        .issue     (issue),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_data  (rnd_data),
        .ran_s1    (ran_s1),
        .ran_s2    (ran_s2),
        .ran_s3    (ran_s3),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pass status plus a short history of issued tokens.
    bit               m_busy, m_issuing;
    int               m_next, m_last;
    int               cyc, rcyc;
    bit               h_iss [MAXC];
    int               h_idx [MAXC];
    logic [RND_W-1:0] h_bun [MAXC];

    int obs_done, obs_wr, obs_rdy, done_cyc;
    bit last_iss;
    int last_idx;

    typedef struct {
        string name;
        int    stall_after;
        int    stall_len;
        int    start2_off;
        int    exp_done_off;
        int    exp_wr;
        int    exp_rdy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hv(input int k);
        return (cyc - k >= rcyc) && h_iss[(cyc - k) % MAXC];
    endfunction

    function automatic logic [RND_W-1:0] bundle(input int k);
        logic [R1_W-1:0] r1;
        logic [R2_W-1:0] r2;
        logic [R3_W-1:0] r3;
        r1 = R1_W'(k);
        r2 = R2_W'(32'h100 + k);
        r3 = R3_W'(32'h2000 + k);
        return {r3, r2, r1};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_done"},   done,      0);
        check({tag, "_issue"},  issue,     0);
        check({tag, "_ready"},  rnd_ready, 0);
        check({tag, "_rd_idx"}, rd_idx,    0);
        check({tag, "_ran_s1"}, ran_s1,    0);
        check({tag, "_ran_s2"}, ran_s2,    0);
        check({tag, "_ran_s3"}, ran_s3,    0);
        check({tag, "_wr_en"},  wr_en,     0);
        check({tag, "_wr_idx"}, wr_idx,    0);
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input logic st, input logic v, input logic [RND_W-1:0] d);
        logic             e_iss, e_wr, e_done;
        logic [IDX_W-1:0] e_rd, e_wri;
        logic [R1_W-1:0]  e_s1;
        logic [R2_W-1:0]  e_s2;
        logic [R3_W-1:0]  e_s3;
        logic [RND_W-1:0] b;
        start     = st;
        rnd_valid = v;
        rnd_data  = d;
        @(negedge clk);
        e_iss = m_issuing && v;
        e_rd  = IDX_W'(e_iss ? m_next : m_last);
        e_s1  = e_iss ? d[R1_W-1:0] : '0;
        b     = h_bun[(cyc + MAXC - 1) % MAXC];
        e_s2  = hv(1) ? b[R1_W +: R2_W] : '0;
        b     = h_bun[(cyc + MAXC - 2) % MAXC];
        e_s3  = hv(2) ? b[R1_W + R2_W +: R3_W] : '0;
        e_wr  = hv(3);
        e_wri = IDX_W'(h_idx[(cyc + MAXC - 3) % MAXC]);
        e_done = e_wr && (e_wri == IDX_W'(NBYTES - 1));
        check("busy",      busy,      m_busy);
        check("issue",     issue,     e_iss);
        check("rnd_ready", rnd_ready, e_iss);
        check("rd_idx",    rd_idx,    e_rd);
        check("ran_s1",    ran_s1,    e_s1);
        check("ran_s2",    ran_s2,    e_s2);
        check("ran_s3",    ran_s3,    e_s3);
        check("wr_en",     wr_en,     e_wr);
        check("done",      done,      e_done);
        if (e_wr) check("wr_idx", wr_idx, e_wri);
        if (done)      begin obs_done++; done_cyc = cyc; end
        if (wr_en)     obs_wr++;
        if (rnd_ready) obs_rdy++;
        h_iss[cyc % MAXC] = e_iss;
        h_idx[cyc % MAXC] = m_next;
        h_bun[cyc % MAXC] = d;
        last_iss = e_iss;
        last_idx = m_next;
        @(posedge clk);
        if (e_iss) begin
            m_last = m_next;
            m_next++;
            if (m_next == NBYTES) m_issuing = 0;
        end
        if (!m_busy) begin
            if (st) begin
                m_busy    = 1;
                m_issuing = 1;
                m_next    = 0;
            end
        end else if (e_done) begin
            m_busy = 0;
        end
        cyc++;
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        check({tag, "_held_wr_en"}, wr_en, 0);
        rst_n     = 1'b1;
        m_busy    = 0;
        m_issuing = 0;
        m_next    = 0;
        m_last    = 0;
        cyc++;
        rcyc = cyc;
    endtask

    task automatic run_pass(input vec_t vc);
        int c0, stall_rem;
        bit v;
        obs_done  = 0;
        obs_wr    = 0;
        obs_rdy   = 0;
        done_cyc  = -1;
        stall_rem = 0;
        c0        = cyc;
        step(1'b1, 1'b1, bundle(0));
        for (int n = 1; n < 60 && obs_done == 0; n++) begin
            if (stall_rem > 0) begin
                v = 1'b0;
                stall_rem--;
            end else begin
                v = 1'b1;
            end
            step(n == vc.start2_off, v, v ? bundle(m_next) : '1);
            if (last_iss && last_idx == vc.stall_after) stall_rem = vc.stall_len;
        end
        check({vc.name, "_done_offset"}, done_cyc - c0, vc.exp_done_off);
        check({vc.name, "_done_count"},  obs_done, 1);
        check({vc.name, "_wr_count"},    obs_wr,   vc.exp_wr);
        check({vc.name, "_rdy_count"},   obs_rdy,  vc.exp_rdy);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"nominal",     -1, 0, -1, 19, 16, 16};
        vecs[1] = '{"stall3",       5, 3, -1, 22, 16, 16};
        vecs[2] = '{"stall_first",  0, 1, -1, 20, 16, 16};
        vecs[3] = '{"stall_last",  14, 2, -1, 21, 16, 16};
        vecs[4] = '{"start_busy",  -1, 0,  8, 19, 16, 16};

        m_busy = 0; m_issuing = 0; m_next = 0; m_last = 0;
        cyc = 0; rcyc = 0;
        for (int i = 0; i < MAXC; i++) begin
            h_iss[i] = 0; h_idx[i] = 0; h_bun[i] = '0;
        end

        rst_n     = 1'b0;
        start     = 1'b0;
        rnd_valid = 1'b1;
        rnd_data  = '1;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle cycles: the PRNG offers data but nothing may be consumed.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '1);

        // Directed passes, run back to back: each starts the cycle after done.
        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Reset at c+10 with tokens 6..8 in flight: nothing may follow.
        step(1'b1, 1'b1, bundle(0));
        for (int n = 1; n < 10; n++) step(1'b0, 1'b1, bundle(m_next));
        do_reset("midreset");
        obs_wr = 0; obs_done = 0;
        for (int n = 0; n < 8; n++) step(1'b0, 1'b1, '1);
        check("midreset_no_wr",   obs_wr,   0);
        check("midreset_no_done", obs_done, 0);
        run_pass(vecs[0]);

        // Randomized traffic with occasional starts, stalls and resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_reset");
            end else begin
                step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                     {$urandom, $urandom});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
